// File: rtl/imm_pkg.sv
// Shared immediate-format encodings, signed range limits and the error check
// used by the encoder pipeline.
package imm_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic signed [31:0] IS_MIN = -32'sd2048;
    localparam logic signed [31:0] IS_MAX = 32'sd2047;
    localparam logic signed [31:0] B_MIN  = -32'sd4096;
    localparam logic signed [31:0] B_MAX  = 32'sd4095;
    localparam logic signed [31:0] J_MIN  = -32'sd1048576;
    localparam logic signed [31:0] J_MAX  = 32'sd1048575;

    typedef struct packed {
        logic fmt_err;
        logic align_err;
        logic range_err;
    } imm_err_t;

    function automatic logic in_range(input logic [31:0] imm,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

    // Errors are a pure function of format and immediate, so the pipeline
    // can compute them once when the request is registered.
    function automatic imm_err_t imm_check(input logic [2:0] src,
                                           input logic [31:0] imm);
        imm_err_t e;
        e = '0;
        case (src)
            IMM_I, IMM_S: e.range_err = !in_range(imm, IS_MIN, IS_MAX);
            IMM_B: begin
                e.range_err = !in_range(imm, B_MIN, B_MAX);
                e.align_err = imm[0];
            end
            IMM_U: e.align_err = |imm[11:0];
            IMM_J: begin
                e.range_err = !in_range(imm, J_MIN, J_MAX);
                e.align_err = imm[0];
            end
            default: e.fmt_err = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational placement of immediate bits into a template instruction;
// bits outside the selected format's immediate fields pass through.
module imm_field_pack
    import imm_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [2:0]  src,
    input  logic [31:0] imm,
    output logic [31:0] result
);

    always_comb begin
        result = instr;
        case (src)
            IMM_I: result[31:20] = imm[11:0];
            IMM_S: begin
                result[31:25] = imm[11:5];
                result[11:7]  = imm[4:0];
            end
            IMM_B: begin
                result[31]    = imm[12];
                result[7]     = imm[11];
                result[30:25] = imm[10:5];
                result[11:8]  = imm[4:1];
            end
            IMM_U: result[31:12] = imm[31:12];
            IMM_J: begin
                result[31]    = imm[20];
                result[19:12] = imm[19:12];
                result[20]    = imm[11];
                result[30:21] = imm[10:1];
            end
            default: result = instr;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 captures the request with its error flags,
// S2 holds the packed instruction presented to the consumer.
module imm_encoder
    import imm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [2:0]  in_imm_src,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [2:0]  out_err,
    input  logic        err_clr,
    output logic [15:0] err_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and held data stays stable.
    logic        s1_valid;
    logic [31:0] s1_instr;
    logic [2:0]  s1_src;
    logic [31:0] s1_imm;
    imm_err_t    s1_err;
    logic [31:0] packed_instr;
    logic        s2_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
            s1_src   <= '0;
            s1_imm   <= '0;
            s1_err   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_instr <= in_instr;
                s1_src   <= in_imm_src;
                s1_imm   <= in_imm;
                s1_err   <= imm_check(in_imm_src, in_imm);
            end
        end
    end

    imm_field_pack u_pack (
        .instr  (s1_instr),
        .src    (s1_src),
        .imm    (s1_imm),
        .result (packed_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= packed_instr;
                out_err   <= s1_err;
            end
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (out_valid && out_ready && (out_err != 3'b000)
                     && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: vector table, latency, backpressure,
// error counting and mid-flight reset.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  out_err;
    logic        err_clr;
    logic [15:0] err_count;

    imm_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_imm_src (in_imm_src),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic [2:0]  exp_err;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    int          checks = 0;
    int          errors = 0;
    logic [34:0] exp_q[$];
    logic [15:0] exp_cnt = 16'd0;
    int          ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
    logic        stalled = 1'b0;
    logic [31:0] held_instr;
    logic [2:0]  held_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] instr, input logic [2:0] src,
                           input logic [31:0] imm, input logic [31:0] ei, input logic [2:0] ee);
        vecs[i].instr     = instr;
        vecs[i].src       = src;
        vecs[i].imm       = imm;
        vecs[i].exp_instr = ei;
        vecs[i].exp_err   = ee;
    endtask

    // driver: present a request at a negedge and hold it until accepted
    task automatic send(input int i);
        int n;
        n = 0;
        exp_q.push_back({vecs[i].exp_err, vecs[i].exp_instr});
        in_valid   = 1'b1;
        in_instr   = vecs[i].instr;
        in_imm_src = vecs[i].src;
        in_imm     = vecs[i].imm;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (ready_mode == 0)      out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else                      out_ready = 1'b0;
    end

    // scoreboard: compare each delivered result and held values under stall
    always begin
        logic [34:0] e;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_instr", out_instr, held_instr);
                check("stall_err", 32'(out_err), 32'(held_err));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", out_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("out_instr", out_instr, e[31:0]);
                    check("out_err", 32'(out_err), 32'(e[34:32]));
                    if (e[34:32] != 3'b000 && exp_cnt != 16'hFFFF) exp_cnt++;
                end
            end
            stalled    = out_valid && !out_ready;
            held_instr = out_instr;
            held_err   = out_err;
        end
    end

    initial begin
        set_vec(0,  32'h00000013, 3'd0, 32'hFFFFFFFF, 32'hFFF00013, 3'b000);
        set_vec(1,  32'h00000013, 3'd0, 32'h000007FF, 32'h7FF00013, 3'b000);
        set_vec(2,  32'h00000013, 3'd0, 32'hFFFFF7FF, 32'h7FF00013, 3'b001);
        set_vec(3,  32'h00000023, 3'd1, 32'h000007FF, 32'h7E000FA3, 3'b000);
        set_vec(4,  32'h00000023, 3'd1, 32'h00000800, 32'h80000023, 3'b001);
        set_vec(5,  32'h00000023, 3'd1, 32'hFFFFF800, 32'h80000023, 3'b000);
        set_vec(6,  32'h00000063, 3'd2, 32'hFFFFF000, 32'h80000063, 3'b000);
        set_vec(7,  32'h00000063, 3'd2, 32'h00001000, 32'h80000063, 3'b001);
        set_vec(8,  32'h00000063, 3'd2, 32'h00000003, 32'h00000163, 3'b010);
        set_vec(9,  32'h00000063, 3'd2, 32'h00000FFE, 32'h7E000FE3, 3'b000);
        set_vec(10, 32'h00000037, 3'd3, 32'h12345001, 32'h12345037, 3'b010);
        set_vec(11, 32'h00000037, 3'd3, 32'hABCDE000, 32'hABCDE037, 3'b000);
        set_vec(12, 32'h0000006F, 3'd4, 32'h000FFFFE, 32'h7FFFF06F, 3'b000);
        set_vec(13, 32'h0000006F, 3'd4, 32'hFFF00000, 32'h8000006F, 3'b000);
        set_vec(14, 32'h0000006F, 3'd4, 32'h00100000, 32'h8000006F, 3'b001);
        set_vec(15, 32'h0000006F, 3'd4, 32'h00000001, 32'h0000006F, 3'b010);
        set_vec(16, 32'hDEADBEEF, 3'd7, 32'h12345678, 32'hDEADBEEF, 3'b100);
        set_vec(17, 32'hCAFEF00D, 3'd5, 32'h00000000, 32'hCAFEF00D, 3'b100);
        set_vec(18, 32'hABCDE093, 3'd0, 32'h00000123, 32'h123DE093, 3'b000);
        set_vec(19, 32'hFFFFFFFF, 3'd2, 32'h00000000, 32'h01FFF07F, 3'b000);

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_imm_src = '0;
        in_imm     = '0;
        err_clr    = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // latency: accepted at one edge, visible after the next
        @(negedge clk);
        exp_q.push_back({vecs[0].exp_err, vecs[0].exp_instr});
        in_valid   = 1'b1;
        in_instr   = vecs[0].instr;
        in_imm_src = vecs[0].src;
        in_imm     = vecs[0].imm;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        drain();

        for (int i = 0; i < NVEC; i++) send(i);
        drain();
        check("cnt_after_table", 32'(err_count), 32'(exp_cnt));

        // back-to-back under random backpressure
        ready_mode = 1;
        for (int i = 6; i < 14; i++) send(i);
        drain();
        ready_mode = 0;
        drain();
        check("cnt_after_bp", 32'(err_count), 32'(exp_cnt));

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        check("err_clr", 32'(err_count), 32'd0);
        exp_cnt = 16'd0;

        send(16);
        drain();
        check("fmt_cnt", 32'(err_count), 32'd1);

        // reset with both stages full
        ready_mode = 2;
        @(negedge clk);
        send(16);
        send(17);
        @(negedge clk);
        #1;
        check("full_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_cnt", 32'(err_count), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        exp_cnt    = 16'd0;
        ready_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(12);
        drain();
        check("post_rst_cnt", 32'(err_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state rising-edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: in_valid  input  1  request valid.
REQ-004 SHALL have port: in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-005 SHALL have port: in_instr  input  32  template instruction; immediate bit positions are overwritten, all other bits pass through.
REQ-006 SHALL have port: in_imm_src  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J; 101-111 illegal.
REQ-007 SHALL have port: in_imm  input  32  immediate value to encode, two's complement.
REQ-008 SHALL have port: out_valid  output  1  result valid.
REQ-009 SHALL have port: out_ready  input  1  consumer ready.
REQ-010 SHALL have port: out_instr  output  32  encoded instruction.
REQ-011 SHALL have port: out_err  output  3  {fmt_err, align_err, range_err}, qualified by out_valid.
REQ-012 SHALL have port: err_clr  input  1  synchronous clear of err_count.
REQ-013 SHALL have port: err_count  output  16  saturating count of delivered results with any out_err bit set.

Function
REQ-014 SHALL place immediate bits as follows: I [31:20]=imm[11:0]; S [31:25]=imm[11:5], [11:7]=imm[4:0]; B [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; U [31:12]=imm[31:12]; J [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
REQ-015 SHALL set range_err when in_imm is outside the signed range: I/S -2048..2047, B -4096..4095, J -1048576..1048575; U never sets range_err.
REQ-016 SHALL set align_err when B or J in_imm[0]=1, or U in_imm[11:0]!=0; encoding still drops those bits.
REQ-017 SHALL, for an illegal format, set fmt_err only and output in_instr unmodified.
REQ-018 SHALL guarantee round-trip: for out_err==000, re-extracting the immediate from out_instr with the same format and sign-extending yields in_imm exactly.
REQ-019 SHALL be a two-stage pipeline: S1 registers the request and computes errors; S2 holds the packed result; out_instr, out_err and out_valid are driven from S2 registers.
REQ-020 SHALL have a latency of 2 cycles from acceptance to out_valid when out_ready stays high, with throughput of 1 request per cycle.
REQ-021 SHALL advance S1 to S2 when S2 is empty or out_ready=1; in_ready=!S1_valid or S1 advancing (combinational from out_ready, no bubble).
REQ-022 SHALL hold out_instr and out_err stable while out_valid=1 and out_ready=0; no request is lost or duplicated under any backpressure pattern.
REQ-023 SHALL increment err_count on each out_valid and out_ready handshake with out_err!=0, saturating at 0xFFFF; err_clr takes priority over a same-cycle increment and yields 0.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear S1/S2 valid bits, out_valid, out_instr, out_err and err_count to 0; in_ready is 1 during reset.
REQ-025 SHALL discard in-flight requests when reset is asserted mid-operation; the first accept after reset deassertion is on the first rising edge with in_valid=1.

Structure
REQ-026 SHALL take format encodings (IMM_I..IMM_J) and range limit constants from shared package imm_pkg, which the sign-extend logic shares.
REQ-027 SHALL instantiate one combinational sub-module, imm_field_pack (template, format, imm -> packed instruction), between S1 and S2.

Verification
REQ-028 SHALL cover I case: in_instr=0x00000013, src=000, imm=-1 -> out_instr=0xFFF00013, out_err=000, 2 cycles later.
REQ-029 SHALL cover B case: in_instr=0x00000063, imm=-4096 -> out_instr=0x80000063, err=000; imm=4096 -> range_err; imm=3 -> align_err.
REQ-030 SHALL cover J and U cases: J in_instr=0x0000006F, imm=0x000FFFFE -> 0x7FFFF06F; U imm=0x12345001 -> align_err, [31:12]=0x12345.
REQ-031 SHALL cover backpressure: 8 back-to-back requests with out_ready toggling randomly -> 8 results delivered in order, each stable while stalled.
REQ-032 SHALL cover errors and reset: src=111 -> fmt_err, instr unchanged, err_count increments; rst_n pulsed low with both stages full -> out_valid=0, err_count=0 immediately.
